// File: rtl/polyphase_x_sequencer_pkg.sv
// Shared definitions for the horizontal polyphase decimator front end.
// SEL_W has to stay identical to the x-filter's tap select width.
package polyphase_x_sequencer_pkg;

  localparam int PIX_W = 8;   // pixel width
  localparam int MAX_D = 7;   // largest supported decimation factor
  localparam int SEL_W = 3;   // phase select width, covers 0..MAX_D-1
  localparam int CNT_W = 12;  // per-line output counter width

  localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LINE  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // A zero factor means "no decimation"; anything above MAX_D is pinned to MAX_D.
  function automatic logic [SEL_W-1:0] clamp_decim(input logic [SEL_W-1:0] cfg);
    logic [SEL_W-1:0] d;
    d = cfg;
    if (cfg == '0) begin
      d = SEL_ONE;
    end else if (int'(cfg) > MAX_D) begin
      d = SEL_W'(MAX_D);
    end
    return d;
  endfunction

  // Phase counter step: wraps to 0 after D-1.
  function automatic logic [SEL_W-1:0] next_phase(input logic [SEL_W-1:0] ph,
                                                  input logic [SEL_W-1:0] d);
    logic [SEL_W-1:0] n;
    if (ph == d - SEL_ONE) begin
      n = '0;
    end else begin
      n = ph + SEL_ONE;
    end
    return n;
  endfunction

endpackage

// File: rtl/polyphase_x_sequencer.sv
// Tap-load sequencer for the horizontal polyphase FIR decimator.
// Walks sel through 0..D-1 per pixel group, requests one filter output per
// group, edge-replicates the last pixel to finish a partial group at end of
// line, and clears the filter taps for one cycle between lines.
module polyphase_x_sequencer
  import polyphase_x_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] cfg_decim,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_sol,
  input  logic             pix_eol,
  output logic             pix_ready,
  output logic             stream_in,
  output logic [SEL_W-1:0] sel,
  output logic [PIX_W-1:0] cur_p,
  output logic             xout_rdy,
  output logic             line_done,
  output logic [CNT_W-1:0] out_count,
  output logic             sol_err
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] phase_q, phase_d;
  logic [SEL_W-1:0] d_q, d_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [PIX_W-1:0] cur_p_q, cur_p_d;
  logic             stream_in_q, stream_in_d;
  logic             xout_rdy_q, xout_rdy_d;
  logic             line_done_q, line_done_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             sol_err_q, sol_err_d;
  // High for the cycle in which a freshly loaded sel/cur_p pair is on the bus;
  // a held pair during an input bubble must not request a second output.
  logic             pres_q, pres_d;

  logic             accept;
  logic [SEL_W-1:0] d_new;
  logic [SEL_W-1:0] d_m1;

  // Ready is combinational from state so a beat can land in the first LINE cycle.
  assign pix_ready = rst_n && ((state_q == ST_IDLE) || (state_q == ST_LINE));
  assign accept    = pix_valid && pix_ready;
  assign d_new     = clamp_decim(cfg_decim);
  assign d_m1      = d_q - SEL_ONE;

  // Next-state and output-register computation for the line sequencer.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    d_d         = d_q;
    sel_d       = sel_q;
    cur_p_d     = cur_p_q;
    stream_in_d = stream_in_q;
    pres_d      = 1'b0;
    line_done_d = 1'b0;
    sol_err_d   = 1'b0;

    // The last tap of a group was on the bus last cycle: ask for the output now.
    xout_rdy_d  = pres_q && (sel_q == d_m1);
    out_count_d = out_count_q;
    if (xout_rdy_d && (out_count_q != '1)) begin
      out_count_d = out_count_q + CNT_ONE;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!pix_sol) begin
            // Stray beat before any start of line is discarded.
            sol_err_d = 1'b1;
          end else begin
            d_d         = d_new;
            out_count_d = '0;
            cur_p_d     = pix_data;
            sel_d       = '0;
            stream_in_d = 1'b1;
            pres_d      = 1'b1;
            phase_d     = (d_new == SEL_ONE) ? '0 : SEL_ONE;
            if (pix_eol) begin
              state_d = (d_new == SEL_ONE) ? ST_GAP : ST_FLUSH;
            end else begin
              state_d = ST_LINE;
            end
          end
        end
      end

      ST_LINE: begin
        if (accept) begin
          cur_p_d = pix_data;
          sel_d   = phase_q;
          phase_d = next_phase(phase_q, d_q);
          pres_d  = 1'b1;
          if (pix_sol) begin
            // Unexpected start of line is reported but treated as a normal pixel.
            sol_err_d = 1'b1;
          end
          if (pix_eol) begin
            state_d = (phase_q == d_m1) ? ST_GAP : ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        // cur_p holds the last pixel so the partial group is edge-replicated.
        sel_d   = phase_q;
        phase_d = next_phase(phase_q, d_q);
        pres_d  = 1'b1;
        if (phase_q == d_m1) begin
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        // The filter captures the final output with its taps still intact,
        // while the tap clear and line_done go out in the same cycle.
        stream_in_d = 1'b0;
        sel_d       = '0;
        cur_p_d     = '0;
        phase_d     = '0;
        line_done_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any line in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      d_q         <= SEL_ONE;
      sel_q       <= '0;
      cur_p_q     <= '0;
      stream_in_q <= 1'b0;
      xout_rdy_q  <= 1'b0;
      line_done_q <= 1'b0;
      out_count_q <= '0;
      sol_err_q   <= 1'b0;
      pres_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      d_q         <= d_d;
      sel_q       <= sel_d;
      cur_p_q     <= cur_p_d;
      stream_in_q <= stream_in_d;
      xout_rdy_q  <= xout_rdy_d;
      line_done_q <= line_done_d;
      out_count_q <= out_count_d;
      sol_err_q   <= sol_err_d;
      pres_q      <= pres_d;
    end
  end

  assign stream_in = stream_in_q;
  assign sel       = sel_q;
  assign cur_p     = cur_p_q;
  assign xout_rdy  = xout_rdy_q;
  assign line_done = line_done_q;
  assign out_count = out_count_q;
  assign sol_err   = sol_err_q;

endmodule

// File: tb/tb_polyphase_x_sequencer.sv
// Scoreboard bench for polyphase_x_sequencer: directed lines push expected
// tap presentations and pulse events; a negedge monitor pops and compares.
module tb_polyphase_x_sequencer;
  import polyphase_x_sequencer_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [SEL_W-1:0] cfg_decim;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_sol;
  logic             pix_eol;
  logic             pix_ready;
  logic             stream_in;
  logic [SEL_W-1:0] sel;
  logic [PIX_W-1:0] cur_p;
  logic             xout_rdy;
  logic             line_done;
  logic [CNT_W-1:0] out_count;
  logic             sol_err;

  polyphase_x_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_decim (cfg_decim),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_sol   (pix_sol),
    .pix_eol   (pix_eol),
    .pix_ready (pix_ready),
    .stream_in (stream_in),
    .sel       (sel),
    .cur_p     (cur_p),
    .xout_rdy  (xout_rdy),
    .line_done (line_done),
    .out_count (out_count),
    .sol_err   (sol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int pix;
    int rdy;
  } pres_t;

  pres_t pq[$];  // expected tap presentations (sel, cur_p, pix_ready)
  int    xq[$];  // expected out_count at each xout_rdy pulse
  int    dq[$];  // expected out_count at each line_done pulse
  int    eq[$];  // one token per expected sol_err pulse

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pp(input int s, input int p, input int r);
    pres_t e;
    e.sel = s;
    e.pix = p;
    e.rdy = r;
    pq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one beat; it is accepted at the posedge after pix_ready is seen high.
  task automatic send(input int data, input bit sol, input bit eol, input int cfg);
    int n;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = PIX_W'(data);
    pix_sol   = sol;
    pix_eol   = eol;
    cfg_decim = SEL_W'(cfg);
    n = 0;
    while (!pix_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) chk("ready_timeout", int'(pix_ready), 1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sol   = 1'b0;
    pix_eol   = 1'b0;
  endtask

  // Monitor: a new (sel, cur_p) pair while stream_in is high is one presentation.
  bit               pv;
  logic [SEL_W-1:0] ps;
  logic [PIX_W-1:0] pc;

  initial begin
    pres_t e;
    int    x;
    pv = 1'b0;
    ps = '0;
    pc = '0;
    forever begin
      @(negedge clk);
      if (rst_n && stream_in) begin
        if (!pv || sel != ps || cur_p != pc) begin
          chk("pres_pending", int'(pq.size() > 0), 1);
          if (pq.size() > 0) begin
            e = pq.pop_front();
            chk("pres_sel", int'(sel), e.sel);
            chk("pres_cur_p", int'(cur_p), e.pix);
            chk("pres_ready", int'(pix_ready), e.rdy);
          end
        end
        pv = 1'b1;
        ps = sel;
        pc = cur_p;
      end else begin
        pv = 1'b0;
      end
      if (xout_rdy) begin
        chk("xout_pending", int'(xq.size() > 0), 1);
        if (xq.size() > 0) begin
          x = xq.pop_front();
          chk("xout_count", int'(out_count), x);
        end
      end
      if (line_done) begin
        chk("done_pending", int'(dq.size() > 0), 1);
        if (dq.size() > 0) begin
          x = dq.pop_front();
          chk("done_count", int'(out_count), x);
          chk("done_stream_in", int'(stream_in), 0);
          chk("done_sel", int'(sel), 0);
          chk("done_cur_p", int'(cur_p), 0);
          chk("done_xout", int'(xout_rdy), 1);
        end
      end
      if (sol_err) begin
        chk("err_pending", int'(eq.size() > 0), 1);
        if (eq.size() > 0) x = eq.pop_front();
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_ready"}, int'(pix_ready), 0);
    chk({tag, "_stream_in"}, int'(stream_in), 0);
    chk({tag, "_sel"}, int'(sel), 0);
    chk({tag, "_cur_p"}, int'(cur_p), 0);
    chk({tag, "_xout_rdy"}, int'(xout_rdy), 0);
    chk({tag, "_line_done"}, int'(line_done), 0);
    chk({tag, "_out_count"}, int'(out_count), 0);
    chk({tag, "_sol_err"}, int'(sol_err), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_sol   = 1'b0;
    pix_eol   = 1'b0;
    cfg_decim = '0;
    idle(2);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    idle(2);
    chk("idle_ready", int'(pix_ready), 1);

    // D=3, six pixels back to back: two full groups, eol on sel=2.
    pp(0, 10, 1); pp(1, 20, 1); pp(2, 30, 1);
    pp(0, 40, 1); pp(1, 50, 1); pp(2, 60, 0);
    xq.push_back(1); xq.push_back(2); dq.push_back(2);
    send(10, 1, 0, 3); send(20, 0, 0, 3); send(30, 0, 0, 3);
    send(40, 0, 0, 3); send(50, 0, 0, 3); send(60, 0, 1, 3);
    idle(6);
    chk("t1_out_count_hold", int'(out_count), 2);

    // D=3, four pixels: flush presents sel 1,2 replicating 40.
    pp(0, 10, 1); pp(1, 20, 1); pp(2, 30, 1);
    pp(0, 40, 0); pp(1, 40, 0); pp(2, 40, 0);
    xq.push_back(1); xq.push_back(2); dq.push_back(2);
    send(10, 1, 0, 3); send(20, 0, 0, 3); send(30, 0, 0, 3); send(40, 0, 1, 3);
    idle(8);

    // cfg_decim=0 behaves as D=1: one output per pixel.
    pp(0, 11, 1); pp(0, 12, 1); pp(0, 13, 1); pp(0, 14, 1); pp(0, 15, 0);
    for (int i = 1; i <= 5; i++) xq.push_back(i);
    dq.push_back(5);
    send(11, 1, 0, 0); send(12, 0, 0, 0); send(13, 0, 0, 0);
    send(14, 0, 0, 0); send(15, 0, 1, 0);
    idle(6);
    chk("t3_out_count_hold", int'(out_count), 5);

    // Stray beat in IDLE is dropped with sol_err; then a D=2 line.
    eq.push_back(1);
    send(99, 0, 0, 2);
    idle(3);
    chk("drop_stream_in", int'(stream_in), 0);
    pp(0, 5, 1); pp(1, 6, 0);
    xq.push_back(1); dq.push_back(1);
    send(5, 1, 0, 2); send(6, 0, 1, 2);
    idle(6);

    // D=4 with valid pattern 1,0,0; a mid-line SOL on pixel 23 flags sol_err.
    pp(0, 21, 1); pp(1, 22, 1); pp(2, 23, 1); pp(3, 24, 1);
    pp(0, 25, 1); pp(1, 26, 1); pp(2, 27, 1); pp(3, 28, 0);
    xq.push_back(1); xq.push_back(2); dq.push_back(2);
    eq.push_back(1);
    send(21, 1, 0, 4); idle(2);
    send(22, 0, 0, 4); idle(2);
    send(23, 1, 0, 4); idle(2);
    send(24, 0, 0, 4); idle(2);
    send(25, 0, 0, 4); idle(2);
    send(26, 0, 0, 4); idle(2);
    send(27, 0, 0, 4); idle(2);
    send(28, 0, 1, 4);
    idle(6);

    // D=5 line abandoned by reset after three pixels, then a D=2 line.
    pp(0, 31, 1); pp(1, 32, 1); pp(2, 33, 1);
    send(31, 1, 0, 5); send(32, 0, 0, 5); send(33, 0, 0, 5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    pp(0, 41, 1); pp(1, 42, 1); pp(0, 43, 1); pp(1, 44, 0);
    xq.push_back(1); xq.push_back(2); dq.push_back(2);
    send(41, 1, 0, 2); send(42, 0, 0, 2); send(43, 0, 0, 2); send(44, 0, 1, 2);
    idle(8);
    chk("t6_out_count_hold", int'(out_count), 2);

    chk("pres_left", pq.size(), 0);
    chk("xout_left", xq.size(), 0);
    chk("done_left", dq.size(), 0);
    chk("err_left", eq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/polyphase_x_sequencer.md
Name: polyphase_x_sequencer

Overview:
- Front-end sequencer for the horizontal polyphase FIR decimator (x-filter).
- Accepts a raster pixel stream with valid/ready, start-of-line and end-of-line markers, and drives the x-filter's tap-load interface: stream_in, sel, cur_p and xout_rdy.
- Cycles sel through phases 0..D-1, signals the filter to emit one output per D-pixel group, pads partial groups at end of line and clears the filter taps between lines.

Parameters:
PIX_W, 8, pixel width
MAX_D, 7, maximum decimation factor
SEL_W, 3, phase select width (covers 0..MAX_D-1)
CNT_W, 12, width of the per-line output counter

Ports:
clk  in  1  clock; all logic posedge
rst_n  in  1  reset, asynchronous, active-low
cfg_decim  in  SEL_W  decimation factor D; sampled on the SOL beat; 0 treated as 1
pix_valid  in  1  input beat valid
pix_data  in  PIX_W  input pixel
pix_sol  in  1  beat is first pixel of line
pix_eol  in  1  beat is last pixel of line
pix_ready  out  1  sequencer accepts beat
stream_in  out  1  filter tap enable; low clears filter taps
sel  out  SEL_W  tap/phase index presented with cur_p
cur_p  out  PIX_W  pixel presented to filter
xout_rdy  out  1  one-cycle pulse: filter captures an output this cycle
line_done  out  1  one-cycle pulse in GAP state
out_count  out  CNT_W  outputs produced in current/last line
sol_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset values: pix_ready=0, stream_in=0, sel=0, cur_p=0, xout_rdy=0, line_done=0, out_count=0, sol_err=0, state=IDLE, phase=0, D=1.
- All outputs are registered except pix_ready. pix_ready = (state==IDLE || state==LINE) and rst_n high.
- Accept condition: pix_valid && pix_ready at a posedge.
- The filter samples sel/cur_p on the negedge within the cycle they are presented.
- IDLE:
  - stream_in=0.
  - Accepted beat without pix_sol: dropped; sol_err pulses the next cycle.
  - Accepted beat with pix_sol: latch D=max(cfg_decim,1); clear out_count; cur_p<=pix_data, sel<=0, stream_in<=1, phase<=1 mod D; go to LINE.
  - If pix_eol is also set, apply the LINE eol rule below.
- LINE:
  - Each accepted beat: cur_p<=pix_data, sel<=phase, phase<=(phase==D-1)?0:phase+1.
  - Whenever a beat is presented with sel==D-1, xout_rdy=1 in the following cycle only and out_count increments in that same cycle.
  - No accepted beat: cur_p and sel hold. The repeated tap rewrite with identical data is harmless.
  - pix_sol in LINE: sol_err pulse; beat is processed as an ordinary pixel.
- End of line (beat with pix_eol accepted):
  - If the eol beat's sel==D-1: go to GAP.
  - Otherwise go to FLUSH.
- FLUSH:
  - pix_ready=0; cur_p holds the last pixel (edge replication).
  - Each cycle sel<=phase and phase advances, until sel==D-1 has been presented; then go to GAP.
- GAP (exactly 1 cycle):
  - stream_in=0, sel=0, cur_p=0, line_done=1.
  - The xout_rdy pulse for the final group coincides with this cycle; the filter uses pre-clear tap values.
  - Next state IDLE. out_count holds until the next SOL.
- Latency: first xout_rdy occurs D cycles after the SOL beat is accepted, assuming back-to-back valid beats.
- Throughput: one pixel per cycle; one output per D input pixels.
- out_count saturates at all-ones.
- cfg_decim changes mid-line are ignored.
- Async reset mid-line: all state returns to reset values immediately; the line is abandoned and the next line needs a fresh SOL.

Decomposition:
- Shared package holds:
  - PIX_W, MAX_D and SEL_W; SEL_W must match the x-filter's sel width.
  - State enum: IDLE, LINE, FLUSH, GAP.
- Single module, no sub-modules. The phase counter is small enough to stay inline.

Test Plan:
- D=3, line 10,20,30,40,50,60 back-to-back:
  - sel 0,1,2,0,1,2; cur_p matches input.
  - xout_rdy in the cycles after pixels 30 and 60; out_count=2.
  - line_done one cycle after the last xout_rdy-producing beat; stream_in low 1 cycle.
- D=3, 4-pixel line 10..40:
  - After the 40 beat (sel=0), FLUSH presents sel=1,2 with cur_p=40, pix_ready=0.
  - xout_rdy twice total; out_count=2.
- cfg_decim=0:
  - Treated as D=1; sel always 0; xout_rdy follows every accepted beat.
  - 5-pixel line gives out_count=5.
- Beat without SOL in IDLE:
  - Dropped; sol_err pulses; stream_in stays 0.
  - A subsequent SOL line proceeds normally.
- D=4 with pix_valid toggling 1,0,0,1,...:
  - sel/cur_p hold during gaps; xout_rdy only after sel=3 is presented; phase sequence unbroken.
- rst_n asserted mid-line (D=5, after 3 pixels):
  - All outputs go to reset values asynchronously.
  - After release, a new SOL line with D=2 yields sel 0,1,0,1 and correct counts.
